// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction-decode stage: register file, immediates, load-use hazard, ID/EX register
//
// Optional feature macro: ID_WB_BYPASS_EN
//   When defined, a register read that matches this cycle's write-back target
//   returns wb_data. This is a write-through bypass.
//   When undefined, the read returns the value stored before the write edge.
//
// Ports
//   clk, res          clock; asynchronous active-high reset that clears all state
//   inst_code         instruction from IF/ID (rs1 [19:15], rs2 [24:20], rd [11:7])
//   regwrite, immsel, alusrc, alucontrol, memread, memwrite, memtoreg, acc
//                     decoded controls from IF/ID (immsel: 0 = I-type, 1 = S-type)
//   flush             squash the instruction in ID (taken branch/jump)
//   wb_we, wb_rd, wb_data  register-file write-back port
//   stall             combinational load-use stall back to fetch
//   *_out             ID/EX pipeline register outputs

module id_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic [31:0]       inst_code,
    input  logic              regwrite,
    input  logic              immsel,
    input  logic              alusrc,
    input  logic [3:0]        alucontrol,
    input  logic              memread,
    input  logic              memwrite,
    input  logic              memtoreg,
    input  logic              acc,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic [DATA_W-1:0] rs1_data_out,
    output logic [DATA_W-1:0] rs2_data_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [4:0]        rs1_out,
    output logic [4:0]        rs2_out,
    output logic [4:0]        rd_out,
    output logic              regwrite_out,
    output logic              alusrc_out,
    output logic [3:0]        alucontrol_out,
    output logic              memread_out,
    output logic              memwrite_out,
    output logic              memtoreg_out,
    output logic              acc_out
);

    logic [DATA_W-1:0] r_regs [NREG];

    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_rs1_data;
    logic [DATA_W-1:0] w_rs2_data;
    logic [DATA_W-1:0] w_imm;
    logic              w_hazard;
    logic              w_bubble;
    logic              w_unused_bits;

    assign w_rs1 = inst_code[19:15];
    assign w_rs2 = inst_code[24:20];
    assign w_rd  = inst_code[11:7];

    // Opcode and funct3 are decoded upstream; only the register and immediate fields are used here.
    assign w_unused_bits = ^{inst_code[14:12], inst_code[6:0]};

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    // r0 is forced to zero on read, independent of what the array holds.
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rs1 != 5'd0) begin
            w_rs1_data = r_regs[w_rs1];
`ifdef ID_WB_BYPASS_EN
            if (wb_we && (wb_rd == w_rs1)) begin
                w_rs1_data = wb_data;
            end
`endif
        end
        if (w_rs2 != 5'd0) begin
            w_rs2_data = r_regs[w_rs2];
`ifdef ID_WB_BYPASS_EN
            if (wb_we && (wb_rd == w_rs2)) begin
                w_rs2_data = wb_data;
            end
`endif
        end
    end

    assign w_imm = immsel
        ? {{(DATA_W-12){inst_code[31]}}, inst_code[31:25], inst_code[11:7]}
        : {{(DATA_W-12){inst_code[31]}}, inst_code[31:20]};

    // rs2 only matters when it is a real operand: a register ALU operand or store data.
    assign w_hazard = memread_out && (rd_out != 5'd0) &&
                      ((rd_out == w_rs1) ||
                       ((rd_out == w_rs2) && (!alusrc || memwrite)));
    assign stall    = w_hazard && !flush;
    assign w_bubble = flush || stall;

    always_ff @(posedge clk or posedge res) begin
        if (res || w_bubble) begin
            rs1_data_out   <= '0;
            rs2_data_out   <= '0;
            imm_out        <= '0;
            rs1_out        <= '0;
            rs2_out        <= '0;
            rd_out         <= '0;
            regwrite_out   <= 1'b0;
            alusrc_out     <= 1'b0;
            alucontrol_out <= '0;
            memread_out    <= 1'b0;
            memwrite_out   <= 1'b0;
            memtoreg_out   <= 1'b0;
            acc_out        <= 1'b0;
        end else begin
            rs1_data_out   <= w_rs1_data;
            rs2_data_out   <= w_rs2_data;
            imm_out        <= w_imm;
            rs1_out        <= w_rs1;
            rs2_out        <= w_rs2;
            rd_out         <= w_rd;
            regwrite_out   <= regwrite;
            alusrc_out     <= alusrc;
            alucontrol_out <= alucontrol;
            memread_out    <= memread;
            memwrite_out   <= memwrite;
            memtoreg_out   <= memtoreg;
            acc_out        <= acc;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage
module tb_id_stage;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] inst_code;
    logic        regwrite, immsel, alusrc, memread, memwrite, memtoreg, acc, flush;
    logic [3:0]  alucontrol;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [31:0] rs1_data_out, rs2_data_out, imm_out;
    logic [4:0]  rs1_out, rs2_out, rd_out;
    logic        regwrite_out, alusrc_out, memread_out, memwrite_out, memtoreg_out, acc_out;
    logic [3:0]  alucontrol_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .res(res), .inst_code(inst_code), .regwrite(regwrite), .immsel(immsel),
        .alusrc(alusrc), .alucontrol(alucontrol), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .acc(acc), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .rs1_data_out(rs1_data_out),
        .rs2_data_out(rs2_data_out), .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rd_out(rd_out), .regwrite_out(regwrite_out), .alusrc_out(alusrc_out),
        .alucontrol_out(alucontrol_out), .memread_out(memread_out),
        .memwrite_out(memwrite_out), .memtoreg_out(memtoreg_out), .acc_out(acc_out)
    );

    // ctrl bit layout: [9] regwrite [8] alusrc [7:4] alucontrol [3] memread [2] memwrite [1] memtoreg [0] acc
    typedef struct {
        logic [31:0] inst;
        logic        immsel;
        logic [9:0]  ctrl;
        logic        flush;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        e_stall;
        logic [31:0] e_rs1d, e_rs2d, e_imm;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [9:0]  e_ctrl;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(logic [31:0] inst, logic immsel, logic [9:0] ctrl, logic fl,
                                logic we, logic [4:0] wrd, logic [31:0] wdat, logic e_stall,
                                logic [31:0] e_rs1d, logic [31:0] e_rs2d, logic [31:0] e_imm,
                                logic [4:0] e_rs1, logic [4:0] e_rs2, logic [4:0] e_rd,
                                logic [9:0] e_ctrl);
        vec_t v;
        v.inst = inst; v.immsel = immsel; v.ctrl = ctrl; v.flush = fl;
        v.wb_we = we; v.wb_rd = wrd; v.wb_data = wdat; v.e_stall = e_stall;
        v.e_rs1d = e_rs1d; v.e_rs2d = e_rs2d; v.e_imm = e_imm;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_rd = e_rd; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    function automatic logic [120:0] pack(logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                                          logic [4:0] s1, logic [4:0] s2, logic [4:0] d,
                                          logic [9:0] c);
        return {a, b, imm, s1, s2, d, c};
    endfunction

    function automatic logic [120:0] dut_out();
        return pack(rs1_data_out, rs2_data_out, imm_out, rs1_out, rs2_out, rd_out,
                    {regwrite_out, alusrc_out, alucontrol_out, memread_out,
                     memwrite_out, memtoreg_out, acc_out});
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] inst, input logic isel, input logic [9:0] ctrl,
                         input logic fl, input logic we, input logic [4:0] wrd,
                         input logic [31:0] wdat);
        inst_code = inst;
        immsel    = isel;
        {regwrite, alusrc, alucontrol, memread, memwrite, memtoreg, acc} = ctrl;
        flush     = fl;
        wb_we     = we;
        wb_rd     = wrd;
        wb_data   = wdat;
    endtask

    // Reference model: architectural register contents plus the expected ID/EX contents.
    logic [31:0]  m_regs[32];
    logic [120:0] m_idex;
    logic         m_memread;
    logic [4:0]   m_rd;

    function automatic logic [31:0] m_read(logic [4:0] idx, logic we, logic [4:0] wrd,
                                           logic [31:0] wdat);
        if (idx == 0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (we && wrd == idx) return wdat;
`endif
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_idex = '0;
        m_memread = 1'b0;
        m_rd = 5'd0;
    endtask

    task automatic random_cycle(input int k);
        logic [31:0] inst, wdat, imm;
        logic [9:0]  ctrl;
        logic        isel, fl, we, hz, e_stall;
        logic [4:0]  s1, s2, d, wrd;
        logic signed [11:0] s12;
        logic [120:0] nxt;
        @(negedge clk);
        inst = $urandom;
        s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
        inst[19:15] = s1; inst[24:20] = s2; inst[11:7] = d;
        ctrl = 10'($urandom);
        ctrl[3] = 1'($urandom_range(0, 1));
        isel = 1'($urandom);
        fl = ($urandom_range(0, 7) == 0);
        we = 1'($urandom);
        wrd = 5'($urandom_range(0, 7));
        wdat = $urandom;
        apply(inst, isel, ctrl, fl, we, wrd, wdat);
        hz = m_memread && (m_rd != 0) && ((m_rd == s1) || ((m_rd == s2) && (!ctrl[8] || ctrl[2])));
        e_stall = hz && !fl;
        s12 = isel ? {inst[31:25], inst[11:7]} : inst[31:20];
        imm = int'(s12);
        nxt = (fl || e_stall) ? '0
            : pack(m_read(s1, we, wrd, wdat), m_read(s2, we, wrd, wdat), imm, s1, s2, d, ctrl);
        #1 check($sformatf("rand%0d_stall", k), 128'(stall), 128'(e_stall));
        @(posedge clk);
        if (we && wrd != 0) m_regs[wrd] = wdat;
        m_idex = nxt;
        m_memread = nxt[3];
        m_rd = nxt[14:10];
        #1 check($sformatf("rand%0d_idex", k), 128'(dut_out()), 128'(m_idex));
    endtask

    logic [31:0] bypass_val;

    initial begin
`ifdef ID_WB_BYPASS_EN
        bypass_val = 32'h1234;
`else
        bypass_val = 32'h0;
`endif
        //            inst          isel ctrl    fl we rd  wdata          stl rs1d   rs2d   imm            s1 s2  d   ectrl
        tbl[0]  = mk(32'h0000_0000, 0, 10'h000, 0, 1, 5, 32'h0000_00AA, 0, 0,     0,     0,             0, 0,  0, 10'h000);
        tbl[1]  = mk(32'h0002_8333, 0, 10'h200, 0, 1, 0, 32'hFFFF_FFFF, 0, 32'hAA, 0,    0,             5, 0,  6, 10'h200);
        tbl[2]  = mk(32'h0000_0013, 0, 10'h200, 0, 1, 2, 32'h0000_0055, 0, 0,     0,     0,             0, 0,  0, 10'h200);
        tbl[3]  = mk(32'hFFC1_0093, 0, 10'h300, 0, 0, 0, 0,             0, 32'h55, 0,    32'hFFFF_FFFC, 2, 28, 1, 10'h300);
        tbl[4]  = mk(32'h0011_2123, 1, 10'h104, 0, 0, 0, 0,             0, 32'h55, 0,    32'h2,         2, 1,  2, 10'h104);
        tbl[5]  = mk(32'h0031_2183, 0, 10'h30A, 0, 0, 0, 0,             0, 32'h55, 0,    32'h3,         2, 3,  3, 10'h30A);
        tbl[6]  = mk(32'h0051_8133, 0, 10'h200, 0, 0, 0, 0,             1, 0,     0,     0,             0, 0,  0, 10'h000);
        tbl[7]  = mk(32'h0051_8133, 0, 10'h200, 0, 0, 0, 0,             0, 0,     32'hAA, 32'h5,        3, 5,  2, 10'h200);
        tbl[8]  = mk(32'h0031_2183, 0, 10'h30A, 0, 0, 0, 0,             0, 32'h55, 0,    32'h3,         2, 3,  3, 10'h30A);
        tbl[9]  = mk(32'h0052_0133, 0, 10'h200, 0, 0, 0, 0,             0, 0,     32'hAA, 32'h5,        4, 5,  2, 10'h200);
        tbl[10] = mk(32'h0031_2183, 0, 10'h30A, 0, 0, 0, 0,             0, 32'h55, 0,    32'h3,         2, 3,  3, 10'h30A);
        tbl[11] = mk(32'h0051_8133, 0, 10'h200, 1, 0, 0, 0,             0, 0,     0,     0,             0, 0,  0, 10'h000);
        tbl[12] = mk(32'h0051_8133, 0, 10'h200, 0, 0, 0, 0,             0, 0,     32'hAA, 32'h5,        3, 5,  2, 10'h200);
        tbl[13] = mk(32'h0003_8433, 0, 10'h200, 0, 1, 7, 32'h0000_1234, 0, bypass_val, 0, 0,           7, 0,  8, 10'h200);
        tbl[14] = mk(32'h0003_8433, 0, 10'h200, 0, 0, 0, 0,             0, 32'h1234, 0,  0,             7, 0,  8, 10'h200);

        res = 1'b1;
        apply(32'h0, 0, 10'h0, 0, 0, 0, 0);
        #12;
        check("reset_idex", 128'(dut_out()), 128'(0));
        check("reset_stall", 128'(stall), 128'(0));
        @(negedge clk);
        res = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            apply(tbl[i].inst, tbl[i].immsel, tbl[i].ctrl, tbl[i].flush, tbl[i].wb_we,
                  tbl[i].wb_rd, tbl[i].wb_data);
            #1 check($sformatf("tbl%0d_stall", i), 128'(stall), 128'(tbl[i].e_stall));
            @(posedge clk);
            #1 check($sformatf("tbl%0d_idex", i), 128'(dut_out()),
                     128'(pack(tbl[i].e_rs1d, tbl[i].e_rs2d, tbl[i].e_imm, tbl[i].e_rs1,
                               tbl[i].e_rs2, tbl[i].e_rd, tbl[i].e_ctrl)));
        end

        // Reset asserted mid-stall cancels the stall; the held instruction then decodes normally.
        @(negedge clk);
        apply(32'h0031_2183, 0, 10'h30A, 0, 0, 0, 0);
        @(negedge clk);
        apply(32'h0051_8133, 0, 10'h200, 0, 0, 0, 0);
        #1 check("midstall_stall_before", 128'(stall), 128'(1));
        #1 res = 1'b1;
        #1 check("midstall_stall_reset", 128'(stall), 128'(0));
        check("midstall_idex_reset", 128'(dut_out()), 128'(0));
        @(negedge clk);
        res = 1'b0;
        #1 check("after_reset_stall", 128'(stall), 128'(0));
        @(posedge clk);
        #1 check("after_reset_idex", 128'(dut_out()),
                 128'(pack(0, 0, 32'h5, 5'd3, 5'd5, 5'd2, 10'h200)));

        // Randomised run from a fresh reset against the reference model.
        @(negedge clk);
        res = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        res = 1'b0;
        for (int k = 0; k < 400; k++) begin
            random_cycle(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of the IF/ID pipeline register.
- Holds the 32-entry integer register file and its write-back port, plus the immediate generator and load-use hazard detection.
- Ends in the ID/EX pipeline register that feeds the execute stage.
- Raises stall back to fetch so the PC and IF/ID register hold for one cycle.

Parameters:
- DATA_W, 32, register/operand width
- NREG, 32, number of architectural registers (index width clog2(NREG) = 5)

Ports:
- clk  in  1  clock, all state updates on posedge
- res  in  1  reset, asynchronous, active-high; clears all state immediately
- inst_code  in  32  instruction from IF/ID
- regwrite  in  1  decoded control from IF/ID
- immsel  in  1  0 = I-type immediate, 1 = S-type immediate
- alusrc  in  1  decoded control from IF/ID
- alucontrol  in  4  decoded control from IF/ID
- memread  in  1  decoded control from IF/ID
- memwrite  in  1  decoded control from IF/ID
- memtoreg  in  1  decoded control from IF/ID
- acc  in  1  decoded control from IF/ID
- flush  in  1  taken branch/jump; squash the instruction in ID
- wb_we  in  1  write-back enable
- wb_rd  in  5  write-back destination
- wb_data  in  DATA_W  write-back value
- stall  out  1  combinational; fetch holds PC and IF/ID when high
- rs1_data_out  out  DATA_W  ID/EX registered operand 1
- rs2_data_out  out  DATA_W  ID/EX registered operand 2
- imm_out  out  DATA_W  ID/EX registered immediate
- rs1_out  out  5  ID/EX registered source index (for forwarding)
- rs2_out  out  5  ID/EX registered source index (for forwarding)
- rd_out  out  5  ID/EX registered destination index
- regwrite_out, alusrc_out, memread_out, memwrite_out, memtoreg_out, acc_out  out  1 each  ID/EX registered controls
- alucontrol_out  out  4  ID/EX registered ALU control

Behaviour:
- Field extraction:
  - rs1 = inst_code[19:15], rs2 = inst_code[24:20], rd = inst_code[11:7].
- Register file:
  - 32 x DATA_W; write on posedge when wb_we=1 and wb_rd!=0.
  - Reads are combinational.
  - r0 always reads 0; writes to r0 are ignored.
- Immediate:
  - immsel=0: sign-extend inst_code[31:20].
  - immsel=1: sign-extend {inst_code[31:25], inst_code[11:7]}.
- Hazard detection (combinational):
  - hazard = memread_out & (rd_out!=0) & ((rd_out==rs1) | ((rd_out==rs2) & (~alusrc | memwrite))).
  - stall = hazard & ~flush.
- ID/EX update each posedge:
  - flush=1: load bubble (all controls 0, indices 0, data 0); flush has priority over stall.
  - Else stall=1: load bubble. IF/ID holds the same instruction, so it re-decodes next cycle.
  - Else: capture decoded fields, register-file reads, immediate and all controls.
- Latency:
  - A non-stalled instruction appears at the ID/EX outputs 1 cycle after it is presented.
  - A load-use pair costs exactly 1 bubble; stall deasserts on the next cycle because the bubble clears memread_out.
- Reset (res=1, asynchronous):
  - All ID/EX outputs = 0 and all 32 registers = 0; stall = 0 follows from memread_out = 0.
  - Asserting res mid-stall cancels the stall; the first instruction after reset decodes normally.
- Simultaneous write-back and read of the same register: defined by the optional feature below.
- wb_we with wb_rd=0 while an instruction reads r0: the read returns 0.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - If wb_we=1, wb_rd!=0 and wb_rd matches rs1/rs2, the corresponding read returns wb_data in the same cycle (write-through).
  - The WB-to-ID distance-3 hazard is therefore covered without a stall.
- Undefined:
  - Reads return the pre-write value.
  - The new value is visible to reads from the cycle after the write edge.

Test Plan:
- Reset then write: res pulse; wb_we=1, wb_rd=5, wb_data=32'h0000_00AA; next cycle decode add r6,r5,r0 (inst 32'h0002_8333) -> rs1_data_out=32'hAA, rs2_data_out=0, rd_out=6, regwrite_out=1.
- r0 protection: wb_we=1, wb_rd=0, wb_data=32'hFFFF_FFFF; then read r0 -> rs1_data_out=0.
- Immediates:
  - addi r1,r2,-4 (32'hFFC1_0093, immsel=0) -> imm_out=32'hFFFF_FFFC.
  - sw r1,2(r2) (32'h0011_2123, immsel=1) -> imm_out=32'h0000_0002.
- Load-use:
  - lw r3,3(r2) then add r2,r3,r5 -> stall=1 for exactly 1 cycle and ID/EX receives a bubble (all controls 0).
  - Next cycle the add is captured with rs1_out=3.
  - No stall when the follower instead reads r4,r5.
- Flush over stall: same load-use pair with flush=1 on the stall cycle -> stall=0 and ID/EX bubble.
- Bypass (ID_WB_BYPASS_EN defined): wb_rd=7, wb_data=32'h1234 written in the same cycle as a read of r7 -> rs1_data_out=32'h1234. With the macro undefined, the read returns the old value 0.
